// File: rtl/canyon_rom_loader.sv
// Canyon ROM loader: steers an HPS byte download into the prog/pf/mo/sync ROM write
// ports, validates the image length and holds the game core in reset until a good load.
`timescale 1ns/1ps
module canyon_rom_loader #(
  parameter int TOTAL_BYTES = 5152,
  parameter int STRETCH     = 16
) (
  input  logic        Clk_12_I,
  input  logic        Reset_I,
  input  logic        dn_download_I,
  input  logic        dn_wr_I,
  input  logic [16:0] dn_addr_I,
  input  logic [7:0]  dn_data_I,
  output logic [11:0] rom_addr_O,
  output logic [7:0]  rom_data_O,
  output logic        prog_we_O,
  output logic        pf_we_O,
  output logic        mo_we_O,
  output logic        sync_we_O,
  output logic        Core_Reset_O,
  output logic        done_O,
  output logic        err_O,
  output logic [15:0] checksum_O
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STRETCH,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int             SCW          = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [SCW-1:0] STRETCH_LAST = SCW'(STRETCH - 1);
  localparam logic [12:0]    TOTAL_CNT    = 13'(TOTAL_BYTES);
  localparam logic [12:0]    CNT_MAX      = 13'h1FFF;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_dl_d;
  logic            r_wr_d;
  logic            w_dl_rise;
  logic            w_dl_fall;
  logic            w_wr_rise;
  logic            w_strobe;
  logic [3:0]      w_we_sel;
  logic [11:0]     w_local_addr;
  logic            w_in_range;
  logic            w_count_byte;
  logic            w_oor_byte;
  logic            w_enter_load;
  logic [12:0]     r_cnt;
  logic [12:0]     w_cnt_next;
  logic            r_oor;
  logic            w_oor_next;
  logic [SCW-1:0]  r_stretch_cnt;
  logic [3:0]      r_we;
  logic [11:0]     r_rom_addr;
  logic [7:0]      r_rom_data;
  logic [15:0]     r_checksum;
  logic            r_core_rst;
  logic            r_done;
  logic            r_err;

  assign w_dl_rise = dn_download_I & ~r_dl_d;
  assign w_dl_fall = ~dn_download_I & r_dl_d;
  assign w_wr_rise = dn_wr_I & ~r_wr_d;

  // A strobe landing on the same edge that samples the download fall still belongs
  // to the image, so the previous download level also qualifies it.
  assign w_strobe     = (r_state == S_LOAD) && w_wr_rise && (dn_download_I || r_dl_d);
  assign w_in_range   = |w_we_sel;
  assign w_count_byte = w_strobe && w_in_range;
  assign w_oor_byte   = w_strobe && !w_in_range;
  assign w_oor_next   = r_oor | w_oor_byte;
  assign w_enter_load = (w_state_next == S_LOAD) && (r_state != S_LOAD);

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    w_we_sel     = 4'b0000;
    w_local_addr = 12'h000;
    if (dn_addr_I < 17'h01000) begin
      w_we_sel     = 4'b0001;
      w_local_addr = dn_addr_I[11:0];
    end else if (dn_addr_I < 17'h01200) begin
      w_we_sel     = 4'b0010;
      w_local_addr = {3'b000, dn_addr_I[8:0]};
    end else if (dn_addr_I < 17'h01400) begin
      w_we_sel     = 4'b0100;
      w_local_addr = {3'b000, dn_addr_I[8:0]};
    end else if (dn_addr_I < 17'h01420) begin
      w_we_sel     = 4'b1000;
      w_local_addr = {7'b0000000, dn_addr_I[4:0]};
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_count_byte && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + 13'd1;
    end
  end

  // The length check uses the next count so a byte arriving with the fall is included.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_dl_rise) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_dl_fall) begin
          w_state_next = ((w_cnt_next == TOTAL_CNT) && !w_oor_next) ? S_STRETCH : S_ERROR;
        end
      end
      S_STRETCH: begin
        if (w_dl_rise)                          w_state_next = S_LOAD;
        else if (r_stretch_cnt == STRETCH_LAST) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk_12_I or negedge Reset_I) begin
    if (!Reset_I) begin
      r_state       <= S_IDLE;
      r_dl_d        <= 1'b0;
      r_wr_d        <= 1'b0;
      r_stretch_cnt <= '0;
    end else begin
      r_state       <= w_state_next;
      r_dl_d        <= dn_download_I;
      r_wr_d        <= dn_wr_I;
      r_stretch_cnt <= ((r_state == S_STRETCH) && (w_state_next == S_STRETCH))
                       ? r_stretch_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge Clk_12_I or negedge Reset_I) begin
    if (!Reset_I) begin
      r_we       <= 4'b0000;
      r_rom_addr <= 12'h000;
      r_rom_data <= 8'h00;
      r_cnt      <= 13'd0;
      r_oor      <= 1'b0;
      r_checksum <= 16'h0000;
    end else begin
      r_we <= w_count_byte ? w_we_sel : 4'b0000;
      if (w_count_byte) begin
        r_rom_addr <= w_local_addr;
        r_rom_data <= dn_data_I;
      end
      if (w_enter_load) begin
        r_cnt      <= 13'd0;
        r_oor      <= 1'b0;
        r_checksum <= 16'h0000;
      end else begin
        r_cnt <= w_cnt_next;
        r_oor <= w_oor_next;
        if (w_count_byte) r_checksum <= r_checksum + {8'h00, dn_data_I};
      end
    end
  end

  // Status flags are registered from the next state so they never glitch on decode.
  always_ff @(posedge Clk_12_I or negedge Reset_I) begin
    if (!Reset_I) begin
      r_core_rst <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_core_rst <= (w_state_next == S_DONE);
      r_done     <= (w_state_next == S_DONE);
      r_err      <= (w_state_next == S_ERROR);
    end
  end

  assign rom_addr_O   = r_rom_addr;
  assign rom_data_O   = r_rom_data;
  assign prog_we_O    = r_we[0];
  assign pf_we_O      = r_we[1];
  assign mo_we_O      = r_we[2];
  assign sync_we_O    = r_we[3];
  assign checksum_O   = r_checksum;
  assign Core_Reset_O = r_core_rst;
  assign done_O       = r_done;
  assign err_O        = r_err;

endmodule

// File: tb/tb_canyon_rom_loader.sv
// Self-checking bench for canyon_rom_loader: a decode vector table, full-image and
// corner-case downloads, and random bursts scored against an address-map model.
`timescale 1ns/1ps
module tb_canyon_rom_loader;

  localparam int TOTAL        = 5152;
  localparam int STRETCH_CLKS = 16;

  logic        Clk_12_I = 1'b0;
  logic        Reset_I;
  logic        dn_download_I;
  logic        dn_wr_I;
  logic [16:0] dn_addr_I;
  logic [7:0]  dn_data_I;
  logic [11:0] rom_addr_O;
  logic [7:0]  rom_data_O;
  logic        prog_we_O;
  logic        pf_we_O;
  logic        mo_we_O;
  logic        sync_we_O;
  logic        Core_Reset_O;
  logic        done_O;
  logic        err_O;
  logic [15:0] checksum_O;

  canyon_rom_loader #(
    .TOTAL_BYTES(TOTAL),
    .STRETCH    (STRETCH_CLKS)
  ) dut (
    .Clk_12_I     (Clk_12_I),
    .Reset_I      (Reset_I),
    .dn_download_I(dn_download_I),
    .dn_wr_I      (dn_wr_I),
    .dn_addr_I    (dn_addr_I),
    .dn_data_I    (dn_data_I),
    .rom_addr_O   (rom_addr_O),
    .rom_data_O   (rom_data_O),
    .prog_we_O    (prog_we_O),
    .pf_we_O      (pf_we_O),
    .mo_we_O      (mo_we_O),
    .sync_we_O    (sync_we_O),
    .Core_Reset_O (Core_Reset_O),
    .done_O       (done_O),
    .err_O        (err_O),
    .checksum_O   (checksum_O)
  );

  always #5 Clk_12_I = ~Clk_12_I;

  typedef struct {
    int          region;
    logic [11:0] addr;
    logic [7:0]  data;
    int          due;
  } wr_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int          hold;
    logic [3:0]  exp_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  wr_t exp_q[$];
  int  we_cnt[4];
  int  m_count;
  int  m_sum;
  bit  m_oor;

  always @(posedge Clk_12_I) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address map as plain ranges: prog 4 KiB, pf 512, mo 512, sync 32 bytes.
  function automatic int region_of(input int a);
    if (a < 4096)  return 0;
    if (a < 4608)  return 1;
    if (a < 5120)  return 2;
    if (a < TOTAL) return 3;
    return -1;
  endfunction

  function automatic logic [11:0] local_of(input int a);
    case (region_of(a))
      0:       return 12'(a);
      1:       return 12'(a - 4096);
      2:       return 12'(a - 4608);
      3:       return 12'(a - 5120);
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_strobe(input logic [16:0] a, input logic [7:0] d);
    int r;
    wr_t e;
    r = region_of(int'(a));
    if (r < 0) begin
      m_oor = 1'b1;
    end else begin
      if (m_count < 8191) m_count++;
      m_sum    = (m_sum + int'(d)) % 65536;
      e.region = r;
      e.addr   = local_of(int'(a));
      e.data   = d;
      e.due    = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // Every WE pulse must match the oldest expected write, one clock after its strobe.
  always @(negedge Clk_12_I) begin
    logic [3:0] we;
    logic [3:0] ew;
    wr_t        e;
    if (Reset_I) begin
      we = {sync_we_O, mo_we_O, pf_we_O, prog_we_O};
      for (int i = 0; i < 4; i++) if (we[i]) we_cnt[i]++;
      if (we != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 64'(we), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          ew = 4'b0001 << e.region;
          check("write_cyc_we_addr_data",
                64'({20'(cyc), we, rom_addr_O, rom_data_O}),
                64'({20'(e.due), ew, e.addr, e.data}));
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk_12_I);
    #1;
  endtask

  task automatic start_download();
    dn_download_I = 1'b1;
    m_count = 0;
    m_sum   = 0;
    m_oor   = 1'b0;
    step();
  endtask

  task automatic end_download();
    dn_download_I = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [16:0] a, input logic [7:0] d, input int hold);
    dn_addr_I = a;
    dn_data_I = d;
    dn_wr_I   = 1'b1;
    if (dn_download_I) model_strobe(a, d);
    repeat (hold) step();
    dn_wr_I = 1'b0;
    step();
  endtask

  // Final byte whose strobe rises on the very edge that samples the download fall.
  task automatic send_last_with_fall(input logic [16:0] a, input logic [7:0] d);
    dn_addr_I     = a;
    dn_data_I     = d;
    dn_wr_I       = 1'b1;
    dn_download_I = 1'b0;
    model_strobe(a, d);
    step();
    dn_wr_I = 1'b0;
  endtask

  task automatic send_image(input int n, input bit rand_data, input bit fall_on_last);
    for (int a = 0; a < n; a++) begin
      logic [7:0] d;
      d = rand_data ? 8'($urandom) : 8'(a);
      if (fall_on_last && (a == n - 1)) send_last_with_fall(17'(a), d);
      else                              send_byte(17'(a), d, 1);
    end
  endtask

  task automatic check_pending(input string tag);
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // Called right after the edge that sampled the download fall.
  task automatic expect_done(input string tag);
    int n;
    n = 0;
    check({tag, "_stretch_status"}, 64'({Core_Reset_O, done_O, err_O}), 64'(3'b000));
    while (!Core_Reset_O && (n < 100)) begin
      step();
      n++;
    end
    check({tag, "_stretch_clocks"}, 64'(n), 64'(STRETCH_CLKS));
    check({tag, "_done_status"}, 64'({Core_Reset_O, done_O, err_O}), 64'(3'b110));
    check({tag, "_checksum"}, 64'(checksum_O), 64'(m_sum));
    check_pending(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[11];
    int          snap[4];
    int          n;
    logic [16:0] a;

    vecs[0]  = '{17'h00000, 8'h11, 1, 4'b0001, 12'h000, 8'h11};
    vecs[1]  = '{17'h00FFF, 8'h22, 1, 4'b0001, 12'hFFF, 8'h22};
    vecs[2]  = '{17'h01000, 8'h33, 2, 4'b0010, 12'h000, 8'h33};
    vecs[3]  = '{17'h011FF, 8'h44, 1, 4'b0010, 12'h1FF, 8'h44};
    vecs[4]  = '{17'h01200, 8'h55, 1, 4'b0100, 12'h000, 8'h55};
    vecs[5]  = '{17'h01205, 8'hA5, 3, 4'b0100, 12'h005, 8'hA5};
    vecs[6]  = '{17'h013FF, 8'h66, 1, 4'b0100, 12'h1FF, 8'h66};
    vecs[7]  = '{17'h01400, 8'h77, 1, 4'b1000, 12'h000, 8'h77};
    vecs[8]  = '{17'h0141F, 8'h88, 4, 4'b1000, 12'h01F, 8'h88};
    vecs[9]  = '{17'h01420, 8'h99, 1, 4'b0000, 12'h01F, 8'h88};
    vecs[10] = '{17'h1FFFF, 8'hAA, 1, 4'b0000, 12'h01F, 8'h88};
    for (int r = 0; r < 4; r++) we_cnt[r] = 0;
    m_count = 0;
    m_sum   = 0;
    m_oor   = 1'b0;

    // Reset held with busy inputs: everything must stay cleared.
    Reset_I       = 1'b0;
    dn_download_I = 1'b1;
    dn_wr_I       = 1'b1;
    dn_addr_I     = 17'h01205;
    dn_data_I     = 8'hFF;
    repeat (3) step();
    check("reset_outputs", 64'({rom_addr_O, rom_data_O, prog_we_O, pf_we_O, mo_we_O,
          sync_we_O, Core_Reset_O, done_O, err_O, checksum_O}), 64'(0));
    dn_download_I = 1'b0;
    dn_wr_I       = 1'b0;
    step();
    Reset_I = 1'b1;
    repeat (2) step();
    check("idle_status", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b000));

    // Decode table: one region/boundary per row, out-of-range rows leave outputs alone.
    start_download();
    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < 4; r++) snap[r] = we_cnt[r];
      send_byte(vecs[i].addr, vecs[i].data, vecs[i].hold);
      check($sformatf("vec%0d_we_pulses", i),
            64'({8'(we_cnt[3] - snap[3]), 8'(we_cnt[2] - snap[2]),
                 8'(we_cnt[1] - snap[1]), 8'(we_cnt[0] - snap[0])}),
            64'({7'd0, vecs[i].exp_we[3], 7'd0, vecs[i].exp_we[2],
                 7'd0, vecs[i].exp_we[1], 7'd0, vecs[i].exp_we[0]}));
      check($sformatf("vec%0d_addr_data", i), 64'({rom_addr_O, rom_data_O}),
            64'({vecs[i].exp_addr, vecs[i].exp_data}));
    end
    check("table_checksum", 64'(checksum_O), 64'(m_sum));
    end_download();
    check("table_oor_error", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b001));
    check_pending("table");

    // Full image, data = low address byte.
    for (int r = 0; r < 4; r++) we_cnt[r] = 0;
    start_download();
    send_image(TOTAL, 1'b0, 1'b0);
    check("full_region_pulses", 64'({16'(we_cnt[0]), 16'(we_cnt[1]), 16'(we_cnt[2]), 16'(we_cnt[3])}),
          64'({16'd4096, 16'd512, 16'd512, 16'd32}));
    end_download();
    expect_done("full");

    // One byte short, then a good image with random data.
    start_download();
    send_image(TOTAL - 1, 1'b1, 1'b0);
    end_download();
    check("short_error", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b001));
    repeat (20) step();
    check("short_error_held", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b001));
    check_pending("short");
    start_download();
    send_image(TOTAL, 1'b1, 1'b0);
    end_download();
    expect_done("good_after_short");

    // Full image plus one out-of-range byte.
    for (int r = 0; r < 4; r++) we_cnt[r] = 0;
    start_download();
    send_image(TOTAL, 1'b1, 1'b0);
    send_byte(17'h01420, 8'h5A, 1);
    check("extra_total_pulses", 64'(we_cnt[0] + we_cnt[1] + we_cnt[2] + we_cnt[3]), 64'(TOTAL));
    check("extra_checksum", 64'(checksum_O), 64'(m_sum));
    end_download();
    check("extra_error", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b001));
    check_pending("extra");

    // Asynchronous reset in the middle of a load discards the partial image.
    start_download();
    for (int i = 0; i < 100; i++) send_byte(17'(i), 8'($urandom), 1);
    check("partial_checksum", 64'(checksum_O), 64'(m_sum));
    check_pending("partial");
    Reset_I = 1'b0;
    #1;
    check("async_reset_outputs", 64'({rom_addr_O, rom_data_O, prog_we_O, pf_we_O, mo_we_O,
          sync_we_O, Core_Reset_O, done_O, err_O, checksum_O}), 64'(0));
    dn_download_I = 1'b0;
    repeat (2) step();
    Reset_I = 1'b1;
    step();
    start_download();
    send_image(TOTAL, 1'b1, 1'b0);
    end_download();
    expect_done("after_reset");

    // Last strobe coincides with the download fall, then the stretch is aborted.
    start_download();
    send_image(TOTAL, 1'b1, 1'b1);
    check("coincident_in_stretch", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b000));
    repeat (5) step();
    check_pending("coincident");
    start_download();
    check("abort_cleared_checksum", 64'(checksum_O), 64'(0));
    repeat (20) step();
    check("abort_core_held", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b000));
    end_download();
    check("abort_empty_load_error", 64'({Core_Reset_O, done_O, err_O}), 64'(3'b001));

    // Random short bursts, some out of range, with random strobe lengths.
    for (int it = 0; it < 4; it++) begin
      start_download();
      n = $urandom_range(5, 30);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 7) == 0) a = 17'($urandom_range(32'h1FFFF, 32'h01420));
        else                           a = 17'($urandom_range(32'h0141F, 0));
        send_byte(a, 8'($urandom), $urandom_range(1, 3));
      end
      check($sformatf("rand%0d_checksum", it), 64'(checksum_O), 64'(m_sum));
      end_download();
      check($sformatf("rand%0d_status", it), 64'({Core_Reset_O, done_O, err_O}), 64'(3'b001));
      send_byte(17'h00010, 8'hC3, 1);
      check($sformatf("rand%0d_idle_strobe_ignored", it), 64'(checksum_O), 64'(m_sum));
      check_pending($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
